spi_byte_master: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, one byte per chip-select frame by default.
- Initiator side of the SPI link feeding the character automaton's slave: host pushes a byte on a valid/ready handshake, the block serializes it on mosi and returns the byte captured from miso.
- Sits between host-side test/control logic and the off-block SPI pins.

---
 rtl/spi_byte_master.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_byte_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// spi_byte_master
//   SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, one byte per chip-select
//   frame. The host hands over a byte on a valid/ready handshake; the block
//   shifts it out on mosi while capturing the slave's reply from miso, then
//   presents the reply on rx_data with a one-cycle rx_valid pulse.
//
//   Frame timeline for a byte accepted in cycle T (D = CLK_DIV):
//     T+1            cs_n low, mosi = bit 7          (SETUP)
//     T+1+D*(2k+1)   sclk rises, miso sampled        (SHIFT)
//     T+1+D*(2k+2)   sclk falls, mosi advances
//     T+1+16*D       8th fall: rx_valid pulse        (HOLD)
//     T+1+17*D       cs_n high                       (GAP)
//     +IDLE_GAP*D    back to IDLE, tx_ready high
//
// Parameters:
//   CLK_DIV   clk cycles per sclk half-period (1..255)
//   IDLE_GAP  CLK_DIV periods cs_n stays high between frames (>=1)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   tx_valid  host byte valid
//   tx_data   byte to transmit
//   tx_ready  block can accept a byte
//   rx_valid  one-cycle pulse, rx_data holds the received byte
//   rx_data   byte captured from miso
//   busy      high whenever the block is not idle
//   sclk      SPI clock, idles low
//   mosi      serial data out
//   miso      serial data in
//   cs_n      chip select, active-low
//
// Optional feature (macro SPI_BYTE_MASTER_BURST_EN):
//   When defined, a byte offered on the 8th-falling-edge cycle is accepted
//   immediately and shifted within the same cs_n frame, skipping HOLD/GAP.
//   When undefined, every byte gets its own cs_n frame.

`timescale 1ns/1ps

module spi_byte_master #(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0]  HALF_MAX = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_MAX  = 16'(IDLE_GAP - 1);

  state_t      state, state_next;
  logic [7:0]  half_cnt, half_cnt_next;
  logic [15:0] gap_cnt, gap_cnt_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic [7:0]  tx_shift, tx_shift_next;
  logic [7:0]  rx_shift, rx_shift_next;
  logic [7:0]  rx_data_next;
  logic        rx_valid_next;
  logic        sclk_next;
  logic        cs_n_next;
  logic        half_done;
  logic        burst_window;
  logic        burst_take;

  assign half_done = (half_cnt == 8'd0);

  // The burst window is the single cycle right after the 8th falling edge,
  // recognisable as HOLD with the rx_valid pulse still high.
`ifdef SPI_BYTE_MASTER_BURST_EN
  assign burst_window = (state == HOLD) && rx_valid;
`else
  assign burst_window = 1'b0;
`endif

  assign burst_take = burst_window && tx_valid;
  assign tx_ready   = (state == IDLE) || burst_window;
  assign busy       = (state != IDLE);

  // mosi is the MSB of the transmit shifter. During a burst hand-over the new
  // byte's MSB must already be on the wire in the accepting cycle, before it
  // has been latched, so it is taken straight from tx_data there.
  assign mosi = burst_take ? tx_data[7] : tx_shift[7];

  // Next-state and datapath logic. The half-period counter reloads by default
  // whenever it expires, since every expiry is either an sclk toggle or a
  // state change; explicit reloads cover the transitions not tied to expiry.
  always_comb begin
    state_next    = state;
    half_cnt_next = half_done ? HALF_MAX : half_cnt - 8'd1;
    gap_cnt_next  = gap_cnt;
    bit_cnt_next  = bit_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    rx_data_next  = rx_data;
    rx_valid_next = 1'b0;
    sclk_next     = sclk;
    cs_n_next     = cs_n;

    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          tx_shift_next = tx_data;
          bit_cnt_next  = 3'd0;
          cs_n_next     = 1'b0;
          half_cnt_next = HALF_MAX;
          state_next    = SETUP;
        end
      end

      SETUP: begin
        if (half_done) begin
          sclk_next     = 1'b1;
          rx_shift_next = {rx_shift[6:0], miso};
          state_next    = SHIFT;
        end
      end

      SHIFT: begin
        if (half_done) begin
          if (sclk) begin
            sclk_next    = 1'b0;
            bit_cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // Last falling edge: mosi keeps bit 0, the reply is complete.
              rx_data_next  = rx_shift;
              rx_valid_next = 1'b1;
              state_next    = HOLD;
            end else begin
              tx_shift_next = {tx_shift[6:0], 1'b0};
            end
          end else begin
            sclk_next     = 1'b1;
            rx_shift_next = {rx_shift[6:0], miso};
          end
        end
      end

      HOLD: begin
        if (burst_take) begin
          // The accepting cycle already counts as the first SETUP cycle, so
          // the counter keeps running instead of reloading; with CLK_DIV=1
          // the first rising edge follows immediately.
          tx_shift_next = tx_data;
          bit_cnt_next  = 3'd0;
          if (half_done) begin
            sclk_next     = 1'b1;
            rx_shift_next = {rx_shift[6:0], miso};
            state_next    = SHIFT;
          end else begin
            state_next = SETUP;
          end
        end else if (half_done) begin
          cs_n_next    = 1'b1;
          gap_cnt_next = GAP_MAX;
          state_next   = GAP;
        end
      end

      GAP: begin
        if (half_done) begin
          if (gap_cnt == 16'd0) begin
            state_next = IDLE;
          end else begin
            gap_cnt_next = gap_cnt - 16'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      half_cnt <= HALF_MAX;
      gap_cnt  <= 16'd0;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      state    <= state_next;
      half_cnt <= half_cnt_next;
      gap_cnt  <= gap_cnt_next;
      bit_cnt  <= bit_cnt_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      rx_data  <= rx_data_next;
      rx_valid <= rx_valid_next;
      sclk     <= sclk_next;
      cs_n     <= cs_n_next;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master
//   Drives spi_byte_master with directed and randomized bytes against a slave
//   model on miso. Each accepted byte pushes its expected reply, mosi byte
//   and frame start cycle onto a scoreboard; an independent monitor checks
//   sclk edge times, the rx_valid pulse, cs_n release and tx_ready return
//   from the frame arithmetic.
//
//   The slave replies with a queued byte when one is provided, otherwise it
//   acts as a small automaton replying 8'h5F + previous command byte.

`timescale 1ns/1ps

module tb_spi_byte_master;

`ifdef SPI_BYTE_MASTER_BURST_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 4;
`endif
  localparam int GAP = 1;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  spi_byte_master #(
    .CLK_DIV (DIV),
    .IDLE_GAP(GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         start;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slave_q[$];
  int         checks;
  int         fails;
  int         cyc;
  logic [7:0] prev_tx;

  // Clock and cycle counter; the counter is read on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Slave model: mode-0 slave, presents the next reply bit after each sclk
  // fall and records the command byte sampled on sclk rises.
  int         s_bit_idx;
  int         s_cap_bits;
  logic [7:0] s_cap;
  logic [7:0] s_last_cmd;
  logic [7:0] s_resp;
  bit         s_loaded;
  logic       s_prev_sclk;

  initial begin
    miso        = 1'b0;
    s_bit_idx   = 0;
    s_cap_bits  = 0;
    s_cap       = 8'h00;
    s_last_cmd  = 8'h00;
    s_resp      = 8'h00;
    s_loaded    = 1'b0;
    s_prev_sclk = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n || cs_n) begin
      s_bit_idx  = 0;
      s_cap_bits = 0;
      s_loaded   = 1'b0;
      miso       = 1'b0;
    end else begin
      if (sclk && !s_prev_sclk) begin
        s_cap = {s_cap[6:0], mosi};
        s_cap_bits++;
        if (s_cap_bits == 8) begin
          s_last_cmd = s_cap;
          s_cap_bits = 0;
        end
      end
      if (!sclk && s_prev_sclk) begin
        s_bit_idx++;
        if (s_bit_idx == 8) begin
          s_bit_idx = 0;
          s_loaded  = 1'b0;
        end
      end
      if (!s_loaded) begin
        if (slave_q.size() > 0) s_resp = slave_q.pop_front();
        else s_resp = 8'h5F + s_last_cmd;
        s_loaded = 1'b1;
      end
      miso = s_resp[7 - s_bit_idx];
    end
    s_prev_sclk = sclk;
  end

  // Monitor: compares DUT behaviour against the scoreboard entries.
  logic       m_prev_sclk;
  logic       m_prev_cs;
  logic       m_prev_ready;
  logic [7:0] m_cap;
  logic [7:0] m_last_rx;
  int         m_rise_idx;
  int         m_frame_rises;
  int         m_frame_pulses;
  int         m_last_frame_rises;
  int         m_last_rx_cyc;
  int         m_last_cs_cyc;
  exp_t       m_e;

  initial begin
    m_prev_sclk        = 1'b0;
    m_prev_cs          = 1'b1;
    m_prev_ready       = 1'b0;
    m_cap              = 8'h00;
    m_last_rx          = 8'h00;
    m_rise_idx         = 0;
    m_frame_rises      = 0;
    m_frame_pulses     = 0;
    m_last_frame_rises = 0;
    m_last_rx_cyc      = 0;
    m_last_cs_cyc      = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rise_idx     = 0;
      m_frame_rises  = 0;
      m_frame_pulses = 0;
      m_last_rx      = 8'h00;
    end else begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected rx_valid", 32'(rx_valid), 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          checkOutput("rx_data", 32'(rx_data), 32'(m_e.rx));
          checkOutput("mosi byte", 32'(m_cap), 32'(m_e.tx));
          checkOutput("rx_valid cycle", 32'(cyc), 32'(m_e.start + 16 * DIV));
          checkOutput("rises per byte", 32'(m_rise_idx), 32'd8);
          m_last_rx = m_e.rx;
        end
        m_rise_idx    = 0;
        m_frame_pulses++;
        m_last_rx_cyc = cyc;
      end else if (rx_data !== m_last_rx) begin
        checkOutput("rx_data hold", 32'(rx_data), 32'(m_last_rx));
      end

      if (sclk && !m_prev_sclk) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected sclk rise", 32'(sclk), 32'd0);
        end else begin
          checkOutput("sclk rise cycle", 32'(cyc),
                      32'(exp_q[0].start + DIV * (2 * m_rise_idx + 1)));
        end
        m_cap = {m_cap[6:0], mosi};
        m_rise_idx++;
        m_frame_rises++;
      end

      if (cs_n && !m_prev_cs) begin
        checkOutput("cs_n release cycle", 32'(cyc), 32'(m_last_rx_cyc + DIV));
        checkOutput("rises per frame", 32'(m_frame_rises), 32'(8 * m_frame_pulses));
        m_last_frame_rises = m_frame_rises;
        m_frame_rises      = 0;
        m_frame_pulses     = 0;
        m_last_cs_cyc      = cyc;
      end

      if (cs_n && sclk) begin
        checkOutput("sclk low while cs_n high", 32'(sclk), 32'd0);
      end

      if (tx_ready && !m_prev_ready && cs_n) begin
        checkOutput("tx_ready return cycle", 32'(cyc), 32'(m_last_cs_cyc + GAP * DIV));
      end

`ifndef SPI_BYTE_MASTER_BURST_EN
      if (tx_ready && !cs_n) begin
        checkOutput("tx_ready inside frame", 32'(tx_ready), 32'd0);
      end
`endif
    end
    m_prev_sclk  = sclk;
    m_prev_cs    = cs_n;
    m_prev_ready = tx_ready;
  end

  // Issue one byte. The reply comes from the slave queue when use_resp is
  // set, otherwise from the automaton rule. tx_valid stays high with junk
  // data for 'hold' extra cycles, which the DUT must ignore.
  task automatic applyStimulus(input logic [7:0] data, input bit use_resp,
                               input logic [7:0] resp, input int hold);
    exp_t e;
    int   wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!(tx_ready && cs_n) && wait_cnt < 1000) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 1000) begin
      checkOutput("tx_ready wait timeout", 32'd0, 32'd1);
      return;
    end
    e.tx    = data;
    e.rx    = use_resp ? resp : 8'(8'h5F + prev_tx);
    e.start = cyc + 1;
    if (use_resp) slave_q.push_back(resp);
    exp_q.push_back(e);
    prev_tx  = data;
    tx_valid = 1'b1;
    tx_data  = data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tx_data = 8'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int wait_cnt;
    wait_cnt = 0;
    @(negedge clk);
    while (!(tx_ready && cs_n && !busy) && wait_cnt < 1000) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 1000) checkOutput("idle wait timeout", 32'd0, 32'd1);
  endtask

  // Start a frame and pull rst_n low on its 4th sclk rise.
  task automatic resetMidFrame(input logic [7:0] data);
    logic [7:0] saved;
    logic       p;
    int         rises;
    int         n;
    saved = prev_tx;
    applyStimulus(data, 1'b1, 8'($urandom), 0);
    rises = 0;
    n     = 0;
    p     = sclk;
    while (rises < 4 && n < 40 * DIV) begin
      @(negedge clk);
      if (sclk && !p) rises++;
      p = sclk;
      n++;
    end
    checkOutput("4th rise reached", 32'(rises), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort {cs_n,sclk,busy,rx_valid}", 32'({cs_n, sclk, busy, rx_valid}), 32'h8);
    @(negedge clk);
    rst_n   = 1'b1;
    prev_tx = saved;
    slave_q.delete();
    repeat (20 * DIV) @(negedge clk);
  endtask

`ifdef SPI_BYTE_MASTER_BURST_EN
  task automatic burstPair(input logic [7:0] a, input logic [7:0] ra,
                           input logic [7:0] b, input logic [7:0] rb);
    exp_t e;
    int   t;
    int   n;
    bit   seen;
    @(negedge clk);
    n = 0;
    while (!(tx_ready && cs_n) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    slave_q.push_back(ra);
    slave_q.push_back(rb);
    t       = cyc;
    e.tx    = a;
    e.rx    = ra;
    e.start = t + 1;
    exp_q.push_back(e);
    e.tx    = b;
    e.rx    = rb;
    e.start = t + 1 + 16 * DIV;
    exp_q.push_back(e);
    prev_tx  = b;
    tx_valid = 1'b1;
    tx_data  = a;
    @(negedge clk);
    tx_data = b;
    seen    = 1'b0;
    n       = 0;
    while (!seen && n < 40 * DIV) begin
      @(negedge clk);
      if (tx_ready) begin
        seen = 1'b1;
        checkOutput("burst accept cycle", 32'(cyc), 32'(t + 1 + 16 * DIV));
        checkOutput("burst cs_n low", 32'(cs_n), 32'd0);
        checkOutput("burst mosi msb", 32'(mosi), 32'(b[7]));
      end
      n++;
    end
    checkOutput("burst window seen", 32'(seen), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    waitIdle();
    checkOutput("burst frame rises", 32'(m_last_frame_rises), 32'd16);
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    prev_tx  = 8'h00;
    checks   = 0;
    fails    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: outputs hold their reset values.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle {cs_n,sclk,mosi,tx_ready,busy,rx_valid}",
                  32'({cs_n, sclk, mosi, tx_ready, busy, rx_valid}), 32'h24);
    end
    checkOutput("idle rx_data", 32'(rx_data), 32'h00);

    // Directed byte with a fixed reply.
    applyStimulus(8'hA5, 1'b1, 8'h3C, 0);

    // Automaton slave: command 8'h03, then 8'h00 returns 'b'.
    applyStimulus(8'h03, 1'b0, 8'h00, 0);
    applyStimulus(8'h00, 1'b0, 8'h00, 0);
    waitIdle();
    checkOutput("automaton reply", 32'(rx_data), 32'h62);

    // tx_valid held with changing data during the frame is ignored.
    applyStimulus(8'h96, 1'b1, 8'h71, 10 * DIV);
    applyStimulus(8'h0F, 1'b0, 8'h00, 10 * DIV);

    // Reset mid-frame, then a clean frame.
    resetMidFrame(8'hC3);
    applyStimulus(8'h5A, 1'b1, 8'hE1, 0);

    // Randomized bytes, replies and hold lengths.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                    $urandom_range(0, 8 * DIV));
    end

`ifdef SPI_BYTE_MASTER_BURST_EN
    burstPair(8'h11, 8'h9A, 8'h22, 8'h4B);
`endif

    waitIdle();
    repeat (10) @(negedge clk);
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
